alu_exec_unit: RTL and testbench

//  Execute stage of the single-cycle RISC-V datapath with one registered output stage.
//  - Decodes the 3-bit ALUOp and funct3 (instr[14:12]) into a 4-bit ALU control code.
//  - Runs the 32-bit ALU and produces the zero flag.
//  - Computes PC+4 and PC+imm and selects next PC on branch&zero.
//  - All results are registered: one-cycle latency from in_valid to out_valid.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_ctrl_dec.sv | 31 +++
 rtl/alu_exec_unit.sv | 126 ++++++++++++
 tb/tb_alu_exec_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALUOp encodings, ALU control codes and the R-type funct3 decode
// used by the execute stage.
package alu_pkg;

    // ALUOp values driven by the main control unit
    localparam logic [2:0] ALUOP_MEM       = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH    = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE     = 3'b010;
    localparam logic [2:0] ALUOP_RTYPE_ALT = 3'b011;
    localparam logic [2:0] ALUOP_ITYPE     = 3'b100;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Base funct3 mapping shared by R-type and I-type arithmetic
    function automatic logic [3:0] funct3_to_ctrl(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: ALUOp + funct3 -> 4-bit ALU control code.
// Purely combinational; reserved ALUOp values fall back to ADD.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [2:0] i_alu_op,
    input  logic [2:0] i_funct3,
    output logic [3:0] o_alu_ctrl
);

    // Select the operation from ALUOp, consulting funct3 only for arithmetic types
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_alu_op)
            ALUOP_MEM:    o_alu_ctrl = ALU_ADD;
            ALUOP_BRANCH: o_alu_ctrl = ALU_SUB;
            ALUOP_RTYPE,
            ALUOP_ITYPE:  o_alu_ctrl = funct3_to_ctrl(i_funct3);
            ALUOP_RTYPE_ALT: begin
                if (i_funct3 == 3'b000)
                    o_alu_ctrl = ALU_SUB;
                else if (i_funct3 == 3'b101)
                    o_alu_ctrl = ALU_SRA;
                else
                    o_alu_ctrl = funct3_to_ctrl(i_funct3);
            end
            default:      o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU, zero flag, PC+4 / PC+imm adders and next-PC select,
// all captured in a single output register stage (one-cycle latency).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             branch,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic             pc_sel,
    output logic [WIDTH-1:0] next_pc
);

    // ALU operation on raw operands; shifts use only the low five bits of b
    function automatic logic [WIDTH-1:0] alu_compute(
        input logic [3:0]       ctrl,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [4:0]              sh;
        logic [WIDTH-1:0]        res;
        a_s = a;
        b_s = b;
        sh  = b[4:0];
        case (ctrl)
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_ADD:  res = a + b;
            ALU_XOR:  res = a ^ b;
            ALU_SLL:  res = a << sh;
            ALU_SRL:  res = a >> sh;
            ALU_SUB:  res = a - b;
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SRA:  res = WIDTH'(a_s >>> sh);
            default:  res = '0;
        endcase
        return res;
    endfunction

    logic [3:0]       w_alu_ctrl_p0;
    logic [WIDTH-1:0] w_alu_result_p0;
    logic             w_zero_p0;
    logic [WIDTH-1:0] w_pc_plus4_p0;
    logic [WIDTH-1:0] w_branch_target_p0;
    logic             w_pc_sel_p0;
    logic [WIDTH-1:0] w_next_pc_p0;

    logic             r_vld_p1;
    logic [3:0]       r_alu_ctrl_p1;
    logic [WIDTH-1:0] r_alu_result_p1;
    logic             r_zero_p1;
    logic [WIDTH-1:0] r_pc_plus4_p1;
    logic [WIDTH-1:0] r_branch_target_p1;
    logic             r_pc_sel_p1;
    logic [WIDTH-1:0] r_next_pc_p1;

    alu_ctrl_dec u_ctrl_dec (
        .i_alu_op   (alu_op),
        .i_funct3   (funct3),
        .o_alu_ctrl (w_alu_ctrl_p0)
    );

    // ---- stage p0: combinational execute from current inputs ----
    // Zero comes from the same result that gets registered, so it can never be stale
    always_comb begin
        w_alu_result_p0    = alu_compute(w_alu_ctrl_p0, op_a, op_b);
        w_zero_p0          = (w_alu_result_p0 == '0);
        w_pc_plus4_p0      = pc + WIDTH'(4);
        w_branch_target_p0 = pc + imm;
        w_pc_sel_p0        = branch & w_zero_p0;
        w_next_pc_p0       = w_pc_sel_p0 ? w_branch_target_p0 : w_pc_plus4_p0;
    end

    // ---- stage p1: output register; data holds when no new valid input ----
    // Capture all results on a valid input; clear everything on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p1           <= 1'b0;
            r_alu_ctrl_p1      <= '0;
            r_alu_result_p1    <= '0;
            r_zero_p1          <= 1'b0;
            r_pc_plus4_p1      <= '0;
            r_branch_target_p1 <= '0;
            r_pc_sel_p1        <= 1'b0;
            r_next_pc_p1       <= '0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_alu_ctrl_p1      <= w_alu_ctrl_p0;
                r_alu_result_p1    <= w_alu_result_p0;
                r_zero_p1          <= w_zero_p0;
                r_pc_plus4_p1      <= w_pc_plus4_p0;
                r_branch_target_p1 <= w_branch_target_p0;
                r_pc_sel_p1        <= w_pc_sel_p0;
                r_next_pc_p1       <= w_next_pc_p0;
            end
        end
    end

    assign out_valid     = r_vld_p1;
    assign alu_ctrl      = r_alu_ctrl_p1;
    assign alu_result    = r_alu_result_p1;
    assign zero          = r_zero_p1;
    assign pc_plus4      = r_pc_plus4_p1;
    assign branch_target = r_branch_target_p1;
    assign pc_sel        = r_pc_sel_p1;
    assign next_pc       = r_next_pc_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors with hand-computed
// expectations queued at issue time and checked by an independent monitor.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [2:0]  alu_op;
    logic [2:0]  funct3;
    logic        branch;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        out_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        pc_sel;
    logic [31:0] next_pc;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic [31:0] pc4;
        logic [31:0] bt;
        logic        sel;
        logic [31:0] npc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .alu_op        (alu_op),
        .funct3        (funct3),
        .branch        (branch),
        .op_a          (op_a),
        .op_b          (op_b),
        .pc            (pc),
        .imm           (imm),
        .out_valid     (out_valid),
        .alu_ctrl      (alu_ctrl),
        .alu_result    (alu_result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .pc_sel        (pc_sel),
        .next_pc       (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        chk({tag, ".alu_result"}, alu_result, 32'd0);
        chk({tag, ".zero"}, 32'(zero), 32'd0);
        chk({tag, ".pc_plus4"}, pc_plus4, 32'd0);
        chk({tag, ".branch_target"}, branch_target, 32'd0);
        chk({tag, ".pc_sel"}, 32'(pc_sel), 32'd0);
        chk({tag, ".next_pc"}, next_pc, 32'd0);
    endtask

    task automatic randomize_inputs();
        alu_op = 3'($urandom);
        funct3 = 3'($urandom);
        branch = 1'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        pc     = $urandom;
        imm    = $urandom;
    endtask

    // Drive one valid transaction (called just after a rising edge) and queue its expectation
    task automatic issue(
        input string       name,
        input logic [2:0]  t_op,
        input logic [2:0]  t_f3,
        input logic        t_br,
        input logic [31:0] t_a,
        input logic [31:0] t_b,
        input logic [31:0] t_pc,
        input logic [31:0] t_imm,
        input logic [3:0]  e_ctrl,
        input logic [31:0] e_res,
        input logic        e_zero,
        input logic [31:0] e_pc4,
        input logic [31:0] e_bt,
        input logic        e_sel,
        input logic [31:0] e_npc
    );
        exp_t e;
        alu_op = t_op; funct3 = t_f3; branch = t_br;
        op_a = t_a; op_b = t_b; pc = t_pc; imm = t_imm;
        in_valid = 1'b1;
        e.name = name; e.ctrl = e_ctrl; e.res = e_res; e.zero = e_zero;
        e.pc4 = e_pc4; e.bt = e_bt; e.sel = e_sel; e.npc = e_npc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            randomize_inputs();
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a valid result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, ".alu_ctrl"}, 32'(alu_ctrl), 32'(e.ctrl));
                    chk({e.name, ".alu_result"}, alu_result, e.res);
                    chk({e.name, ".zero"}, 32'(zero), 32'(e.zero));
                    chk({e.name, ".pc_plus4"}, pc_plus4, e.pc4);
                    chk({e.name, ".branch_target"}, branch_target, e.bt);
                    chk({e.name, ".pc_sel"}, 32'(pc_sel), 32'(e.sel));
                    chk({e.name, ".next_pc"}, next_pc, e.npc);
                end
            end
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        in_valid = 1'b1;
        randomize_inputs();
        #3;
        chk_all_zero("reset_async");
        @(posedge clk); #1;
        randomize_inputs();
        @(posedge clk); #1;
        chk_all_zero("reset_held");

        in_valid = 1'b0;
        reset = 1'b1;
        idle(2);
        chk("post_reset_idle.out_valid", 32'(out_valid), 32'd0);

        // load/store address add with negative offset
        issue("add_ld", 3'b000, 3'b000, 1'b0, 32'd100, 32'hFFFF_FFFC, 32'h0, 32'h0,
              4'b0010, 32'd96, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        idle(1);
        chk("hold.out_valid", 32'(out_valid), 32'd0);
        chk("hold.alu_result", alu_result, 32'd96);
        chk("hold.alu_ctrl", 32'(alu_ctrl), 32'h2);

        // taken branch, equal operands
        issue("beq_taken", 3'b001, 3'b000, 1'b1, 32'd7, 32'd7, 32'h40, 32'hFFFF_FFF8,
              4'b0110, 32'h0, 1'b1, 32'h44, 32'h38, 1'b1, 32'h38);
        // not-taken branch: 1-2 = -1
        issue("beq_not", 3'b001, 3'b000, 1'b1, 32'd1, 32'd2, 32'h80, 32'h10,
              4'b0110, 32'hFFFF_FFFF, 1'b0, 32'h84, 32'h90, 1'b0, 32'h84);
        // SRA, shift amount from low five bits only (0x21 -> 1)
        issue("sra", 3'b011, 3'b101, 1'b0, 32'h8000_0000, 32'h21, 32'h100, 32'h10,
              4'b1001, 32'hC000_0000, 1'b0, 32'h104, 32'h110, 1'b0, 32'h104);
        idle(1);
        issue("slt", 3'b010, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0,
              4'b0111, 32'd1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        // SLTU result 0 with branch=1 exercises pc_sel from a zero ALU result
        issue("sltu", 3'b010, 3'b011, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h20,
              4'b1000, 32'd0, 1'b1, 32'h204, 32'h220, 1'b1, 32'h220);
        issue("and", 3'b010, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'h0, 32'h0,
              4'b0000, 32'h30, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        issue("or", 3'b010, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'h0, 32'h0,
              4'b0001, 32'hFF, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        issue("sll", 3'b010, 3'b001, 1'b0, 32'h1, 32'h25, 32'h0, 32'h0,
              4'b0100, 32'h20, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        issue("sub_r", 3'b011, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0,
              4'b0110, 32'hFFFF_FFFE, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        issue("srl_i", 3'b100, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'h0,
              4'b0101, 32'h0800_0000, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        issue("xor_i", 3'b100, 3'b100, 1'b0, 32'hFF, 32'h0F, 32'h0, 32'h0,
              4'b0011, 32'hF0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);
        issue("reserved", 3'b111, 3'b100, 1'b0, 32'd3, 32'd4, 32'h0, 32'h0,
              4'b0010, 32'd7, 1'b0, 32'h4, 32'h0, 1'b0, 32'h4);

        // Reset pulsed while the next transaction is in flight
        issue("pre_rst", 3'b000, 3'b000, 1'b0, 32'd10, 32'd20, 32'h1000, 32'h8,
              4'b0010, 32'd30, 1'b0, 32'h1004, 32'h1008, 1'b0, 32'h1004);
        alu_op = 3'b000; funct3 = 3'b000; branch = 1'b0;
        op_a = 32'd1; op_b = 32'd1; pc = 32'h2000; imm = 32'h4;
        in_valid = 1'b1;
        #6;
        reset = 1'b0;
        #1;
        chk_all_zero("reset_mid");
        @(posedge clk); #1;
        chk_all_zero("reset_mid_held");
        in_valid = 1'b0;
        reset = 1'b1;
        idle(1);
        chk("post_mid_reset.out_valid", 32'(out_valid), 32'd0);
        // PC adder wrap
        issue("pc_wrap", 3'b000, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8,
              4'b0010, 32'd0, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0);
        idle(3);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
